// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state type, default sizing and pointer helper for the score sequencer
package score_pkg;

    localparam int SCORE_NUM_REQ = 4;
    localparam int SCORE_VAL_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// rtl/score_sequencer_if.sv - scoring event request/ack bundle between point sources and the sequencer
interface score_sequencer_if
    import score_pkg::*;
#(
    parameter int NUM_REQ = SCORE_NUM_REQ,
    parameter int VAL_W   = SCORE_VAL_W
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0][VAL_W-1:0] value;
    logic [NUM_REQ-1:0]            ack;

    modport master (output req, output value, input ack);
    modport slave  (input req, input value, output ack);

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or above the pointer, with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (en && !w_found && req[k]) begin
                w_found = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - shares the score counter between point sources, expanding each event into a strobe burst
module score_sequencer
    import score_pkg::*;
#(
    parameter int NUM_REQ = SCORE_NUM_REQ,
    parameter int VAL_W   = SCORE_VAL_W
) (
    input  logic                       clk,
    input  logic                       reset,
    score_sequencer_if.slave           req_if,
    input  logic                       freeze,
    input  logic                       won,
    output logic                       score_update,
    output logic                       busy,
    output logic                       halted,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [VAL_W-1:0]   r_remaining;
    logic [VAL_W-1:0]   w_remaining_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_nxt;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    w_grant_id_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_arb_en;

    // Grants only in IDLE; won and freeze outrank a request, and reset masks the
    // combinational ack so every output is quiet while reset is held.
    assign w_arb_en = (r_state == IDLE) && !won && !freeze && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .req     (req_if.req),
        .rr_ptr  (r_rr_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        req_if.ack      = '0;
        score_update    = 1'b0;

        case (r_state)
            IDLE: begin
                if (won) begin
                    w_state_nxt = HALT;
                end else if (|w_gnt) begin
                    req_if.ack      = w_gnt;
                    w_remaining_nxt = req_if.value[w_gnt_idx];
                    w_grant_id_nxt  = w_gnt_idx;
                    w_rr_ptr_nxt    = ID_W'(rr_next(int'(w_gnt_idx), NUM_REQ));
                    // A zero-point event is consumed in place and leaves IDLE free next cycle.
                    if (req_if.value[w_gnt_idx] != '0) begin
                        w_state_nxt = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (won) begin
                    w_state_nxt = HALT;
                end else if (!freeze) begin
                    score_update    = 1'b1;
                    w_remaining_nxt = r_remaining - VAL_W'(1);
                    if (r_remaining == VAL_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            HALT: begin
                w_state_nxt = HALT;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (r_state == ISSUE);
    assign halted   = (r_state == HALT);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - directed and randomized checks of score_sequencer against an event-level model
module tb_score_sequencer;
    import score_pkg::*;

    localparam int N  = SCORE_NUM_REQ;
    localparam int W  = SCORE_VAL_W;
    localparam int IW = $clog2(N);

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          freeze = 1'b0;
    logic          won    = 1'b0;
    logic          score_update;
    logic          busy;
    logic          halted;
    logic [IW-1:0] grant_id;

    score_sequencer_if #(.NUM_REQ(N), .VAL_W(W)) req_if ();

    score_sequencer #(.NUM_REQ(N), .VAL_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_if       (req_if.slave),
        .freeze       (freeze),
        .won          (won),
        .score_update (score_update),
        .busy         (busy),
        .halted       (halted),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: points still owed (0 = free to grant), win latch, pointer, last grant.
    int m_rem    = 0;
    int m_ptr    = 0;
    int m_gid    = 0;
    bit m_halted = 1'b0;

    logic [N-1:0]  last_ack;
    logic [N-1:0]  obs_ack;
    logic          obs_su;
    logic          obs_busy;
    logic          obs_halted;
    logic [IW-1:0] obs_gid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic [N-1:0] e_ack;
        logic         e_su;
        int           g;
        @(negedge clk);
        e_ack      = '0;
        e_su       = 1'b0;
        obs_ack    = req_if.ack;
        obs_su     = score_update;
        obs_busy   = busy;
        obs_halted = halted;
        obs_gid    = grant_id;
        check_eq("busy", 32'(busy), 32'(m_rem > 0));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("grant_id", 32'(grant_id), 32'(m_gid));
        if (!m_halted) begin
            if (won) begin
                m_halted = 1'b1;
                m_rem    = 0;
            end else if (!freeze) begin
                if (m_rem > 0) begin
                    e_su  = 1'b1;
                    m_rem = m_rem - 1;
                end else if (req_if.req != '0) begin
                    g = -1;
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && req_if.req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    end
                    e_ack[g] = 1'b1;
                    m_rem    = int'(req_if.value[g]);
                    m_gid    = g;
                    m_ptr    = (g + 1) % N;
                end
            end
        end
        check_eq("ack", 32'(req_if.ack), 32'(e_ack));
        check_eq("score_update", 32'(score_update), 32'(e_su));
        last_ack = e_ack;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must drop without waiting for a clock.
    task automatic do_reset();
        #2;
        req_if.req = '1;
        reset      = 1'b1;
        #1;
        check_eq("rst_ack", 32'(req_if.ack), 32'd0);
        check_eq("rst_score_update", 32'(score_update), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        req_if.req = '0;
        freeze     = 1'b0;
        won        = 1'b0;
        m_rem      = 0;
        m_ptr      = 0;
        m_gid      = 0;
        m_halted   = 1'b0;
        last_ack   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        int e;
        req_if.req   = '0;
        req_if.value = '0;
        last_ack     = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single event of 3 points
        req_if.req      = N'(1);
        req_if.value[0] = W'(3);
        cycle();
        check_eq("single_ack", 32'(obs_ack), 32'd1);
        req_if.req = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("single_strobe", 32'(obs_su), 32'd1);
        end
        cycle();
        check_eq("single_busy_end", 32'(obs_busy), 32'd0);
        check_eq("single_gid", 32'(obs_gid), 32'd0);

        // Round-robin with all requests held, then pointer at 3 with req 1001
        do_reset();
        for (int i = 0; i < N; i++) req_if.value[i] = W'(1);
        for (int s = 0; s < 9; s++) begin
            req_if.req = (s < 7) ? '1 : N'(4'b1001);
            e = (s < 7) ? (s % N) : ((s == 7) ? 3 : 0);
            cycle();
            check_eq("rr_ack", 32'(obs_ack), 32'(1) << e);
            cycle();
            check_eq("rr_strobe", 32'(obs_su), 32'd1);
            check_eq("rr_no_ack_in_issue", 32'(obs_ack), 32'd0);
            check_eq("rr_gid", 32'(obs_gid), 32'(e));
        end
        req_if.req = '0;

        // Zero-value event: consumed with no strobe, next requester granted the following cycle
        req_if.req      = N'(4'b1100);
        req_if.value[2] = '0;
        req_if.value[3] = W'(2);
        cycle();
        check_eq("zero_ack", 32'(obs_ack), 32'd4);
        req_if.req[2] = 1'b0;
        cycle();
        check_eq("zero_next_ack", 32'(obs_ack), 32'd8);
        check_eq("zero_no_strobe", 32'(obs_su), 32'd0);
        req_if.req[3] = 1'b0;
        repeat (2) cycle();
        cycle();
        check_eq("zero_burst_done", 32'(obs_busy), 32'd0);

        // Freeze for two cycles inside a 4-point burst
        req_if.req[0]   = 1'b1;
        req_if.value[0] = W'(4);
        cycle();
        check_eq("frz_ack", 32'(obs_ack), 32'd1);
        req_if.req[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            freeze = (k == 2 || k == 3);
            cycle();
            cnt += int'(obs_su);
        end
        freeze = 1'b0;
        check_eq("frz_strobe_count", 32'(cnt), 32'd4);
        req_if.req[1]   = 1'b1;
        req_if.value[1] = W'(1);
        freeze          = 1'b1;
        repeat (2) begin
            cycle();
            check_eq("frz_idle_no_ack", 32'(obs_ack), 32'd0);
        end
        freeze = 1'b0;
        cycle();
        check_eq("frz_release_ack", 32'(obs_ack), 32'd2);
        req_if.req[1] = 1'b0;
        cycle();

        // Win after 2 of 5 strobes: strobe suppressed that cycle, then permanent HALT
        req_if.req[0]   = 1'b1;
        req_if.value[0] = W'(5);
        cycle();
        check_eq("win_ack", 32'(obs_ack), 32'd1);
        req_if.req[0] = 1'b0;
        repeat (2) cycle();
        won = 1'b1;
        cycle();
        check_eq("win_strobe_masked", 32'(obs_su), 32'd0);
        cycle();
        check_eq("win_halted", 32'(obs_halted), 32'd1);
        req_if.req = '1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (obs_ack != '0 || obs_su || !obs_halted) bad++;
        end
        check_eq("halt_ignores_req", 32'(bad), 32'd0);

        // Asynchronous reset in the middle of a burst
        do_reset();
        req_if.req[1]   = 1'b1;
        req_if.value[1] = W'(7);
        cycle();
        check_eq("mid_ack", 32'(obs_ack), 32'd2);
        req_if.req[1] = 1'b0;
        repeat (2) cycle();
        check_eq("mid_busy", 32'(obs_busy), 32'd1);
        do_reset();
        req_if.req[2]   = 1'b1;
        req_if.value[2] = W'(1);
        cycle();
        check_eq("post_reset_ack", 32'(obs_ack), 32'd4);
        req_if.req[2] = 1'b0;
        cycle();
        check_eq("post_reset_strobe", 32'(obs_su), 32'd1);

        // Randomized requesters, freeze, win and occasional resets
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int t = 0; t < 400; t++) begin
                cycle();
                for (int i = 0; i < N; i++) begin
                    if (last_ack[i]) begin
                        if ($urandom_range(0, 1) == 1) req_if.value[i] = W'($urandom_range(0, (1 << W) - 1));
                        else req_if.req[i] = 1'b0;
                    end else if (!req_if.req[i] && $urandom_range(0, 3) == 0) begin
                        req_if.req[i]   = 1'b1;
                        req_if.value[i] = W'($urandom_range(0, (1 << W) - 1));
                    end
                end
                freeze = ($urandom_range(0, 4) == 0);
                if ((seg % 2) == 1 && t > 150 && $urandom_range(0, 99) == 0) won = 1'b1;
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
